memory_responder: RTL and testbench

Word-organised unified instruction/data memory that serves the multicycle MIPS controller's `memRead`/`memWrite` requests. Accepts one request at a time, waits a fixed configurable latency, then returns read data or commits write data with a one-cycle `memReady` pulse. Sits between the datapath address mux (`IorD`) and the instruction/memory-data registers. Flags misaligned, out-of-range and conflicting requests.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/memory_array.sv | 26 ++
 rtl/memory_responder.sv | 129 ++++++++++++
 tb/tb_memory_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS memory path: FSM states, request error codes
// and the machine word width.
package mips_pkg;

    localparam int unsigned WordWidth = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StBusy    = 2'b01,
        StRespond = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        ErrNone       = 2'b00,
        ErrConflict   = 2'b01,
        ErrMisaligned = 2'b10,
        ErrRange      = 2'b11
    } err_e;

endpackage

// File: rtl/memory_array.sv
// Word-organised storage: one synchronous write port, one asynchronous read port.
module memory_array
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WordWidth-1:0]  i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WordWidth-1:0]  o_rdata
);

    logic [WordWidth-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder for the multicycle MIPS controller: accepts one request,
// waits LATENCY cycles, then pulses o_mem_ready with read data or a rejection flag.
module memory_responder
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 2,
    parameter string       INIT_FILE  = ""
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [31:0]          i_address,
    input  logic [WordWidth-1:0] i_write_data,
    output logic [WordWidth-1:0] o_read_data,
    output logic                 o_mem_ready,
    output logic                 o_error
);

    state_e                r_state, w_state_d;
    logic [3:0]            r_cnt, w_cnt_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic [WordWidth-1:0]  r_wdata, w_wdata_d;
    logic                  r_is_write, w_is_write_d;
    err_e                  r_err, w_err_d;
    logic                  r_ready, w_ready_d;
    logic                  r_error, w_error_d;
    logic [WordWidth-1:0]  r_rdata, w_rdata_d;

    err_e                  w_req_err;
    logic                  w_we;
    logic [WordWidth-1:0]  w_mem_rdata;

    always_comb begin
        if (i_mem_read && i_mem_write) begin
            w_req_err = ErrConflict;
        end else if (i_address[1:0] != 2'b00) begin
            w_req_err = ErrMisaligned;
        end else if ((i_address >> (ADDR_WIDTH + 2)) != 32'd0) begin
            w_req_err = ErrRange;
        end else begin
            w_req_err = ErrNone;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_is_write_d = r_is_write;
        w_err_d      = r_err;
        unique case (r_state)
            StIdle: begin
                if (i_mem_read || i_mem_write) begin
                    w_addr_d     = i_address[ADDR_WIDTH+1:2];
                    w_wdata_d    = i_write_data;
                    w_is_write_d = i_mem_write;
                    w_err_d      = w_req_err;
                    w_cnt_d      = 4'(LATENCY - 1);
                    w_state_d    = (LATENCY == 1) ? StRespond : StBusy;
                end
            end
            StBusy: begin
                w_cnt_d = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_d = StRespond;
                end
            end
            StRespond: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    // Outputs are registered on entry to RESPOND, so they use the next-state latch values;
    // the array cannot change before then because writes commit only when RESPOND ends.
    always_comb begin
        w_ready_d = (w_state_d == StRespond);
        w_error_d = w_ready_d && (w_err_d != ErrNone);
        w_rdata_d = '0;
        if (w_ready_d && !w_is_write_d && (w_err_d == ErrNone)) begin
            w_rdata_d = w_mem_rdata;
        end
    end

    assign w_we = i_rst_n && (r_state == StRespond) && r_is_write && (r_err == ErrNone);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_err      <= ErrNone;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_is_write <= w_is_write_d;
            r_err      <= w_err_d;
            r_ready    <= w_ready_d;
            r_error    <= w_error_d;
            r_rdata    <= w_rdata_d;
        end
    end

    memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (w_addr_d),
        .o_rdata (w_mem_rdata)
    );

    assign o_mem_ready = r_ready;
    assign o_error     = r_error;
    assign o_read_data = r_rdata;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: three instances (LATENCY 2, 1, 15) driven by
// directed requests; a negedge monitor checks data, error flag and response latency.
module tb_memory_responder;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rd    [3];
    logic        wr    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        errv  [3];

    exp_t sb_q[$];
    int   n_cmp;
    int   n_fail;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    memory_responder #(.ADDR_WIDTH(8), .LATENCY(2), .INIT_FILE("")) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(rd[0]), .i_mem_write(wr[0]),
        .i_address(addr[0]), .i_write_data(wdata[0]), .o_read_data(rdata[0]),
        .o_mem_ready(ready[0]), .o_error(errv[0])
    );

    memory_responder #(.ADDR_WIDTH(8), .LATENCY(1), .INIT_FILE("")) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(rd[1]), .i_mem_write(wr[1]),
        .i_address(addr[1]), .i_write_data(wdata[1]), .o_read_data(rdata[1]),
        .o_mem_ready(ready[1]), .o_error(errv[1])
    );

    memory_responder #(.ADDR_WIDTH(8), .LATENCY(15), .INIT_FILE("")) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(rd[2]), .i_mem_write(wr[2]),
        .i_address(addr[2]), .i_write_data(wdata[2]), .o_read_data(rdata[2]),
        .o_mem_ready(ready[2]), .o_error(errv[2])
    );

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: pops one expectation per response strobe.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready[i] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ready inst %0d: got 1 want 0", i);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("resp_inst", 32'(i), 32'(e.inst));
                    chk("resp_data", rdata[i], e.data);
                    chk("resp_error", 32'(errv[i]), 32'(e.err));
                    chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    task automatic req(int i, logic r, logic w, logic [31:0] a, logic [31:0] d,
                       logic [31:0] exp_data, logic exp_err);
        exp_t e;
        bit   seen;
        @(negedge clk);
        rd[i]    = r;
        wr[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        e.inst = i;
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = lat_of(i);
        e.acc  = cyc + 1;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready[i] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout inst %0d addr %h: got no memReady want memReady", i, a);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        rd[i] = 1'b0;
        wr[i] = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", 32'(ready[i]), 32'd0);
            chk("reset_error", 32'(errv[i]), 32'd0);
            chk("reset_rdata", rdata[i], 32'd0);
        end
        rst_n = 1'b1;

        // LATENCY=2 instance: basic write/read, errors, boundaries.
        req(0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        req(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        req(0, 1'b1, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1);
        req(0, 1'b0, 1'b1, 32'h12,  32'h11111111, 32'h0,        1'b1);
        req(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        req(0, 1'b0, 1'b1, 32'h0,   32'hCAFEF00D, 32'h0,        1'b0);
        req(0, 1'b0, 1'b1, 32'h400, 32'h22222222, 32'h0,        1'b1);
        req(0, 1'b1, 1'b0, 32'h0,   32'h0,        32'hCAFEF00D, 1'b0);
        req(0, 1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1);
        req(0, 1'b1, 1'b1, 32'h10,  32'h0BADF00D, 32'h0,        1'b1);
        req(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        req(0, 1'b0, 1'b1, 32'h3FC, 32'h76543210, 32'h0,        1'b0);
        req(0, 1'b1, 1'b0, 32'h3FC, 32'h0,        32'h76543210, 1'b0);
        req(0, 1'b0, 1'b1, 32'h20,  32'hAAAA5555, 32'h0,        1'b0);

        // Reset during BUSY of a write to 0x20 must drop the write and the response.
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
        @(negedge clk);
        rst_n = 1'b0;
        wr[0] = 1'b0;
        @(negedge clk);
        chk("rst_busy_ready", 32'(ready[0]), 32'd0);
        chk("rst_busy_error", 32'(errv[0]), 32'd0);
        chk("rst_busy_rdata", rdata[0], 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_ready", 32'(ready[0]), 32'd0);
        end
        req(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0);

        // LATENCY=1 and LATENCY=15 instances.
        req(1, 1'b0, 1'b1, 32'h40, 32'h01020304, 32'h0,        1'b0);
        req(1, 1'b1, 1'b0, 32'h40, 32'h0,        32'h01020304, 1'b0);
        req(1, 1'b1, 1'b0, 32'h41, 32'h0,        32'h0,        1'b1);
        req(2, 1'b0, 1'b1, 32'h44, 32'hA5A5C3C3, 32'h0,        1'b0);
        req(2, 1'b1, 1'b0, 32'h44, 32'h0,        32'hA5A5C3C3, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
